// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Brief    : Latches instruction fields on the tp5 decode strobe and tracks
//            the extracode and halt flags. Define INSTR_FETCH_CLASS_EN to
//            compile in the one-hot instr_class decode port.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tp5,
  input  logic [14:0] instr,
  output logic [2:0]  OpCode,
  output logic [1:0]  QC,
  output logic        Peripheral_C,
  output logic [11:0] Addr12,
  output logic [9:0]  Addr10,
  output logic        ext_pending,
  output logic        halt
`ifdef INSTR_FETCH_CLASS_EN
  ,
  output logic [11:0] instr_class
`endif
);

  localparam logic [2:0]  c_OP_TC     = 3'b000;
  localparam logic [2:0]  c_OP_CCS    = 3'b001;
  localparam logic [2:0]  c_OP_OTH2   = 3'b010;
  localparam logic [2:0]  c_OP_OTH3   = 3'b011;
  localparam logic [2:0]  c_OP_CS     = 3'b100;
  localparam logic [2:0]  c_OP_QC     = 3'b101;
  localparam logic [2:0]  c_OP_AD     = 3'b110;
  localparam logic [2:0]  c_OP_MASK   = 3'b111;
  localparam logic [11:0] c_EXTEND    = 12'd6;
  localparam logic [11:0] c_HALT_ADDR = 12'hFFF;

  logic [2:0]  w_op;
  logic [1:0]  w_qc;
  logic [11:0] w_addr12;
  logic        w_load;
  logic        w_is_extend;
  logic        w_is_index;
  logic        w_is_halt_word;
  logic        w_ext_next;

  logic [2:0]  r_opcode;
  logic [1:0]  r_qc;
  logic        r_periph;
  logic [11:0] r_addr12;
  logic [9:0]  r_addr10;
  logic        r_ext;
  logic        r_halt;

  assign w_op           = instr[14:12];
  assign w_qc           = instr[11:10];
  assign w_addr12       = instr[11:0];
  // Once halted the unit ignores every strobe until reset.
  assign w_load         = tp5 & ~r_halt;
  assign w_is_extend    = (w_op == c_OP_TC) && (w_addr12 == c_EXTEND);
  assign w_is_index     = (w_op == c_OP_QC) && (w_qc == 2'b00);
  assign w_is_halt_word = (w_op == c_OP_MASK) && (w_addr12 == c_HALT_ADDR);

  always_comb begin
    w_ext_next = 1'b0;
    if (w_is_extend) begin
      w_ext_next = 1'b1;
    end else if (w_is_index) begin
      w_ext_next = r_ext;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opcode <= '0;
      r_qc     <= '0;
      r_periph <= 1'b0;
      r_addr12 <= '0;
      r_addr10 <= '0;
      r_ext    <= 1'b0;
      r_halt   <= 1'b0;
    end else if (w_load) begin
      r_opcode <= w_op;
      r_qc     <= w_qc;
      r_periph <= (w_qc == 2'b00);
      r_addr12 <= w_addr12;
      r_addr10 <= instr[9:0];
      r_ext    <= w_ext_next;
      r_halt   <= w_is_halt_word;
    end
  end

  assign OpCode       = r_opcode;
  assign QC           = r_qc;
  assign Peripheral_C = r_periph;
  assign Addr12       = r_addr12;
  assign Addr10       = r_addr10;
  assign ext_pending  = r_ext;
  assign halt         = r_halt;

`ifdef INSTR_FETCH_CLASS_EN
  logic [11:0] w_class;
  logic [11:0] r_class;

  // Class uses the extracode flag as it stood before this decode.
  always_comb begin
    w_class = '0;
    case (w_op)
      c_OP_TC:   w_class[0] = 1'b1;
      c_OP_CCS:  if (r_ext) w_class[2] = 1'b1; else w_class[1] = 1'b1;
      c_OP_OTH2: w_class[11] = 1'b1;
      c_OP_OTH3: w_class[11] = 1'b1;
      c_OP_CS:   w_class[6] = 1'b1;
      c_OP_QC: begin
        case (w_qc)
          2'b00:   w_class[3]  = 1'b1;
          2'b01:   w_class[11] = 1'b1;
          2'b10:   w_class[4]  = 1'b1;
          default: w_class[5]  = 1'b1;
        endcase
      end
      c_OP_AD:   if (r_ext) w_class[8] = 1'b1; else w_class[7] = 1'b1;
      default:   if (r_ext) w_class[10] = 1'b1; else w_class[9] = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_class <= '0;
    end else if (w_load) begin
      r_class <= w_class;
    end
  end

  assign instr_class = r_class;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// Testbench for instr_fetch_unit: scoreboard against a behavioural model.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        tp5;
  logic [14:0] instr;
  logic [2:0]  OpCode;
  logic [1:0]  QC;
  logic        Peripheral_C;
  logic [11:0] Addr12;
  logic [9:0]  Addr10;
  logic        ext_pending;
  logic        halt;
`ifdef INSTR_FETCH_CLASS_EN
  logic [11:0] instr_class;
`endif

  instr_fetch_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tp5          (tp5),
    .instr        (instr),
    .OpCode       (OpCode),
    .QC           (QC),
    .Peripheral_C (Peripheral_C),
    .Addr12       (Addr12),
    .Addr10       (Addr10),
    .ext_pending  (ext_pending),
    .halt         (halt)
`ifdef INSTR_FETCH_CLASS_EN
    ,
    .instr_class  (instr_class)
`endif
  );

  typedef struct packed {
    logic [2:0]  op;
    logic [1:0]  qc;
    logic        pc;
    logic [11:0] a12;
    logic [9:0]  a10;
    logic        ext;
    logic        hlt;
    logic [11:0] cls;
  } exp_t;

  exp_t q[$];
  exp_t m;
  int   n_cmp = 0;
  int   n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_all(input exp_t e, input string tag);
    chk({tag, " OpCode"},       {29'd0, OpCode},       {29'd0, e.op});
    chk({tag, " QC"},           {30'd0, QC},           {30'd0, e.qc});
    chk({tag, " Peripheral_C"}, {31'd0, Peripheral_C}, {31'd0, e.pc});
    chk({tag, " Addr12"},       {20'd0, Addr12},       {20'd0, e.a12});
    chk({tag, " Addr10"},       {22'd0, Addr10},       {22'd0, e.a10});
    chk({tag, " ext_pending"},  {31'd0, ext_pending},  {31'd0, e.ext});
    chk({tag, " halt"},         {31'd0, halt},         {31'd0, e.hlt});
`ifdef INSTR_FETCH_CLASS_EN
    chk({tag, " instr_class"},  {20'd0, instr_class},  {20'd0, e.cls});
`endif
  endtask

  // Class index straight from the opcode table.
  function automatic logic [11:0] class_of(input int op, input int qc, input bit ext);
    int idx;
    case (op)
      0: idx = 0;
      1: idx = ext ? 2 : 1;
      2, 3: idx = 11;
      4: idx = 6;
      5: idx = (qc == 0) ? 3 : (qc == 1) ? 11 : (qc == 2) ? 4 : 5;
      6: idx = ext ? 8 : 7;
      default: idx = ext ? 10 : 9;
    endcase
    return 12'(1 << idx);
  endfunction

  // Model state after the coming rising edge.
  task automatic model_step(input logic t, input logic [14:0] w);
    int op, qc, a12;
    if (!rst_n) begin
      m = '0;
    end else if (t && !m.hlt) begin
      op  = int'(w[14:12]);
      qc  = int'(w[11:10]);
      a12 = int'(w[11:0]);
      m.cls = class_of(op, qc, m.ext);
      m.op  = w[14:12];
      m.qc  = w[11:10];
      m.pc  = (qc == 0);
      m.a12 = w[11:0];
      m.a10 = w[9:0];
      if (op == 0 && a12 == 6)      m.ext = 1'b1;
      else if (!(op == 5 && qc == 0)) m.ext = 1'b0;
      m.hlt = (op == 7 && a12 == 12'hFFF);
    end
  endtask

  task automatic cycle(input logic rs, input logic t, input logic [14:0] w);
    @(negedge clk);
    rst_n = rs;
    tp5   = t;
    instr = w;
    model_step(t, w);
    q.push_back(m);
  endtask

  // Monitor: every clocked edge has one expected entry.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      check_all(e, "sb");
    end
  end

  task automatic async_reset_check();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    m = '0;
    #1;
    check_all(m, "async_rst");
  endtask

  initial begin
    logic [14:0] w;
    rst_n = 1'b0;
    tp5   = 1'b0;
    instr = '0;
    m     = '0;
    #3;
    check_all(m, "reset");
    cycle(1'b0, 1'b1, 15'h7FFF);
    cycle(1'b0, 1'b0, 15'h0000);

    // Directed scenarios
    cycle(1'b1, 1'b1, 15'h0006);
    cycle(1'b1, 1'b1, 15'h6010);
    cycle(1'b1, 1'b1, 15'h0006);
    cycle(1'b1, 1'b1, 15'h5005);
    cycle(1'b1, 1'b1, 15'h7020);
    cycle(1'b1, 1'b1, 15'h0006);
    cycle(1'b1, 1'b1, 15'h0006);
    cycle(1'b1, 1'b1, 15'h1234);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 15'h5C25);
    cycle(1'b1, 1'b1, 15'h5C25);

    // Randomised decode stream, halt word kept out
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0:       w = 15'h0006;
        1:       w = {5'b10100, 10'($urandom)};
        default: w = 15'($urandom);
      endcase
      if (w == 15'h7FFF) w = 15'h7FFE;
      cycle(1'b1, ($urandom_range(0, 3) != 0), w);
    end

    // Halt and freeze
    cycle(1'b1, 1'b1, 15'h0006);
    cycle(1'b1, 1'b1, 15'h7FFF);
    cycle(1'b1, 1'b1, 15'h1000);
    cycle(1'b1, 1'b1, 15'h0006);
    cycle(1'b1, 1'b0, 15'h5005);
    repeat (2) @(posedge clk);
    async_reset_check();
    cycle(1'b0, 1'b1, 15'h3ABC);
    cycle(1'b1, 1'b1, 15'h1ABC);
    cycle(1'b1, 1'b1, 15'h5800);
    cycle(1'b1, 1'b1, 15'h5400);

    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
